// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the DMEM port arbiter: FSM encodings, address
// alignment and byte-mark values.
package dmem_port_arbiter_pkg;

   localparam logic [0:0] S_PIPE = 1'b0;
   localparam logic [0:0] S_EXT  = 1'b1;

   localparam logic [31:0] DMEM_ALIGN_MASK = 32'hFFFF_FFFC;

   localparam logic [3:0] BM_NONE = 4'b0000;
   localparam logic [3:0] BM_WORD = 4'b1111;

   // DMEM is word addressed; the low two byte-address bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & DMEM_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_rd_tracker.sv
// Remembers who owns the read issued last cycle and steers the
// 1-cycle-latency DMEM read data to that requester.
module dmem_rd_tracker
   import dmem_port_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_grant_i,
   input  logic        rd_ext_i,
   input  logic [31:0] dmem_data_i,
   output logic        ext_rvalid_o,
   output logic [31:0] ext_rdata_o,
   output logic [31:0] pipe_rdata_o
);

   logic rd_pend_q, rd_pend_d;
   logic rd_owner_q, rd_owner_d;

   // Next tag: a granted read is pending next cycle, owned by ext or pipe.
   always_comb begin
      rd_pend_d  = rd_grant_i;
      rd_owner_d = rd_grant_i & rd_ext_i;
   end

   // Tag flops; reset drops any response still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Response steering; the pipeline always sees the raw word.
   always_comb begin
      ext_rvalid_o = rd_pend_q & rd_owner_q;
      ext_rdata_o  = ext_rvalid_o ? dmem_data_i : 32'h0;
      pipe_rdata_o = dmem_data_i;
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single DMEM port between the pipeline MEM stage (primary)
// and an external valid/ready requester, with starvation relief and
// locked external bursts.
//
//  state  | meaning
//  S_PIPE | pipeline has priority; ext wins when pipe idle or starved
//  S_EXT  | locked external burst owns the port
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned MAX_LOCK = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_req_i,
   input  logic        pipe_we_i,
   input  logic [31:0] pipe_addr_i,
   input  logic [31:0] pipe_wdata_i,
   input  logic [3:0]  pipe_bmask_i,
   output logic        pipe_stall_o,
   output logic [31:0] pipe_rdata_o,
   input  logic        ext_valid_i,
   output logic        ext_ready_o,
   input  logic        ext_we_i,
   input  logic        ext_lock_i,
   input  logic [31:0] ext_addr_i,
   input  logic [31:0] ext_wdata_i,
   input  logic [3:0]  ext_bmask_i,
   output logic        ext_rvalid_o,
   output logic [31:0] ext_rdata_o,
   output logic [31:0] DMEM_add_o,
   output logic [3:0]  DMEM_byte_mark_o,
   output logic [31:0] DMEM_data_write_o,
   output logic        DMEM_rd_o,
   input  logic [31:0] DMEM_data_i
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
   localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

   logic [0:0] state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic [3:0] lock_cnt_q, lock_cnt_d;
   logic [3:0] lock_beats;
   logic       ext_grant;
   logic       pipe_grant;
   logic       rd_grant;

   // Grant decision and burst tracking. lock_cnt counts beats already
   // granted in the burst, so a burst never exceeds MAX_LOCK beats in total.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      ext_grant  = 1'b0;
      lock_beats = lock_cnt_q + 4'd1;
      case (state_q)
         S_PIPE: begin
            ext_grant  = ext_valid_i & (~pipe_req_i | (wait_cnt_q == MAX_WAIT_C));
            lock_cnt_d = 4'd0;
            if (ext_grant && ext_lock_i && (MAX_LOCK_C > 4'd1)) begin
               state_d    = S_EXT;
               lock_cnt_d = 4'd1;
            end
         end
         S_EXT: begin
            ext_grant = ext_valid_i;
            if (ext_valid_i && ext_lock_i && (lock_beats < MAX_LOCK_C)) begin
               lock_cnt_d = lock_beats;
            end else begin
               state_d    = S_PIPE;
               lock_cnt_d = 4'd0;
            end
         end
         default: begin
            state_d    = S_PIPE;
            lock_cnt_d = 4'd0;
         end
      endcase
   end

   // Starvation counter: counts blocked ext cycles, saturating at MAX_WAIT.
   always_comb begin
      wait_cnt_d = 4'd0;
      if (ext_valid_i && !ext_grant) begin
         wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
      end
   end

   // Handshake and DMEM drive from whichever requester holds the grant.
   always_comb begin
      pipe_grant        = pipe_req_i & ~ext_grant;
      ext_ready_o       = ext_grant;
      pipe_stall_o      = pipe_req_i & ext_grant;
      DMEM_add_o        = 32'h0;
      DMEM_data_write_o = 32'h0;
      DMEM_byte_mark_o  = BM_NONE;
      DMEM_rd_o         = 1'b0;
      if (ext_grant) begin
         DMEM_add_o        = word_align(ext_addr_i);
         DMEM_data_write_o = ext_wdata_i;
         DMEM_byte_mark_o  = ext_we_i ? ext_bmask_i : BM_NONE;
         DMEM_rd_o         = ~ext_we_i;
      end else if (pipe_grant) begin
         DMEM_add_o        = word_align(pipe_addr_i);
         DMEM_data_write_o = pipe_wdata_i;
         DMEM_byte_mark_o  = pipe_we_i ? pipe_bmask_i : BM_NONE;
         DMEM_rd_o         = ~pipe_we_i;
      end
      rd_grant = (ext_grant & ~ext_we_i) | (pipe_grant & ~pipe_we_i);
   end

   // Arbiter state and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_PIPE;
         wait_cnt_q <= 4'd0;
         lock_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   dmem_rd_tracker u_rd_tracker (
      .clk          (clk),
      .rst          (rst),
      .rd_grant_i   (rd_grant),
      .rd_ext_i     (ext_grant),
      .dmem_data_i  (DMEM_data_i),
      .ext_rvalid_o (ext_rvalid_o),
      .ext_rdata_o  (ext_rdata_o),
      .pipe_rdata_o (pipe_rdata_o)
   );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a behavioural model.
module tb_dmem_port_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int MAX_LOCK = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_req_i = 1'b0, pipe_we_i = 1'b0;
   logic [31:0] pipe_addr_i = '0, pipe_wdata_i = '0;
   logic [3:0]  pipe_bmask_i = '0;
   logic        pipe_stall_o;
   logic [31:0] pipe_rdata_o;
   logic        ext_valid_i = 1'b0, ext_we_i = 1'b0, ext_lock_i = 1'b0;
   logic        ext_ready_o;
   logic [31:0] ext_addr_i = '0, ext_wdata_i = '0;
   logic [3:0]  ext_bmask_i = '0;
   logic        ext_rvalid_o;
   logic [31:0] ext_rdata_o;
   logic [31:0] DMEM_add_o;
   logic [3:0]  DMEM_byte_mark_o;
   logic [31:0] DMEM_data_write_o;
   logic        DMEM_rd_o;
   logic [31:0] DMEM_data_i = '0;

   dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
      .clk               (clk),
      .rst               (rst),
      .pipe_req_i        (pipe_req_i),
      .pipe_we_i         (pipe_we_i),
      .pipe_addr_i       (pipe_addr_i),
      .pipe_wdata_i      (pipe_wdata_i),
      .pipe_bmask_i      (pipe_bmask_i),
      .pipe_stall_o      (pipe_stall_o),
      .pipe_rdata_o      (pipe_rdata_o),
      .ext_valid_i       (ext_valid_i),
      .ext_ready_o       (ext_ready_o),
      .ext_we_i          (ext_we_i),
      .ext_lock_i        (ext_lock_i),
      .ext_addr_i        (ext_addr_i),
      .ext_wdata_i       (ext_wdata_i),
      .ext_bmask_i       (ext_bmask_i),
      .ext_rvalid_o      (ext_rvalid_o),
      .ext_rdata_o       (ext_rdata_o),
      .DMEM_add_o        (DMEM_add_o),
      .DMEM_byte_mark_o  (DMEM_byte_mark_o),
      .DMEM_data_write_o (DMEM_data_write_o),
      .DMEM_rd_o         (DMEM_rd_o),
      .DMEM_data_i       (DMEM_data_i)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   // Model: how long ext has been blocked, how many beats the current locked
   // burst has had (0 = no burst), and whether last cycle issued an ext read.
   int m_blocked = 0;
   int m_burst   = 0;
   bit m_ext_rd  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ext_wins();
      return ext_valid_i && (m_burst > 0 || !pipe_req_i || m_blocked == MAX_WAIT);
   endfunction

   task automatic model_reset();
      m_blocked = 0;
      m_burst   = 0;
      m_ext_rd  = 1'b0;
   endtask

   task automatic model_update();
      bit eg;
      int beats;
      eg = m_ext_wins();
      beats = m_burst + 1;
      if (eg && ext_lock_i && beats < MAX_LOCK) m_burst = beats;
      else m_burst = 0;
      if (ext_valid_i && !eg) m_blocked = (m_blocked < MAX_WAIT) ? m_blocked + 1 : MAX_WAIT;
      else m_blocked = 0;
      m_ext_rd = eg && !ext_we_i;
   endtask

   task automatic model_check();
      bit          eg, pg, we;
      logic [31:0] a, d;
      logic [3:0]  bm;
      eg = m_ext_wins();
      pg = pipe_req_i && !eg;
      a = 32'h0; d = 32'h0; bm = 4'h0; we = 1'b0;
      if (eg) begin a = ext_addr_i; d = ext_wdata_i; bm = ext_bmask_i; we = ext_we_i; end
      else if (pg) begin a = pipe_addr_i; d = pipe_wdata_i; bm = pipe_bmask_i; we = pipe_we_i; end
      a[1:0] = 2'b00;
      chk("ext_ready", ext_ready_o, eg);
      chk("pipe_stall", pipe_stall_o, pipe_req_i && eg);
      chk("dmem_add", DMEM_add_o, a);
      chk("dmem_wdata", DMEM_data_write_o, d);
      chk("dmem_bmark", DMEM_byte_mark_o, we ? bm : 4'h0);
      chk("dmem_rd", DMEM_rd_o, (eg || pg) && !we);
      chk("ext_rvalid", ext_rvalid_o, m_ext_rd);
      chk("ext_rdata", ext_rdata_o, m_ext_rd ? DMEM_data_i : 32'h0);
      chk("pipe_rdata", pipe_rdata_o, DMEM_data_i);
   endtask

   task automatic at_neg();
      @(negedge clk);
      if (check_en) model_check();
   endtask

   task automatic at_pos();
      @(posedge clk);
      if (!rst) model_update();
      #1;
   endtask

   task automatic idle_inputs();
      pipe_req_i = 0; pipe_we_i = 0; pipe_addr_i = '0; pipe_wdata_i = '0; pipe_bmask_i = '0;
      ext_valid_i = 0; ext_we_i = 0; ext_lock_i = 0; ext_addr_i = '0; ext_wdata_i = '0;
      ext_bmask_i = '0; DMEM_data_i = '0;
   endtask

   initial begin
      int ready_cnt;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_en = 1'b1;

      // Reset idle
      at_neg();
      chk("idle_stall", pipe_stall_o, 0);
      chk("idle_ready", ext_ready_o, 0);
      chk("idle_rvalid", ext_rvalid_o, 0);
      chk("idle_bmark", DMEM_byte_mark_o, 4'b0000);
      chk("idle_rd", DMEM_rd_o, 0);
      chk("idle_add", DMEM_add_o, 0);
      chk("idle_wdata", DMEM_data_write_o, 0);
      chk("idle_rdata", ext_rdata_o, 0);
      at_pos();

      // External read only
      ext_valid_i = 1; ext_we_i = 0; ext_addr_i = 32'h0000_0106;
      at_neg();
      chk("xrd_ready", ext_ready_o, 1);
      chk("xrd_add", DMEM_add_o, 32'h0000_0104);
      chk("xrd_rd", DMEM_rd_o, 1);
      at_pos();
      idle_inputs();
      DMEM_data_i = 32'hCAFE_F00D;
      at_neg();
      chk("xrd_rvalid", ext_rvalid_o, 1);
      chk("xrd_rdata", ext_rdata_o, 32'hCAFE_F00D);
      at_pos();
      idle_inputs();
      at_neg(); at_pos();

      // Contention: ext wins every fifth cycle
      pipe_req_i = 1; pipe_we_i = 0; pipe_addr_i = 32'h0000_0200;
      ext_valid_i = 1; ext_we_i = 1; ext_addr_i = 32'h0000_0300;
      ext_wdata_i = 32'h1234_5678; ext_bmask_i = 4'b0011;
      for (int c = 0; c < 10; c++) begin
         at_neg();
         chk("cont_ready", ext_ready_o, (c % 5) == 4);
         chk("cont_stall", pipe_stall_o, (c % 5) == 4);
         at_pos();
      end
      idle_inputs();
      at_neg(); at_pos();

      // Locked burst: 12 beats offered, exactly 8 accepted
      ready_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         ext_valid_i = 1; ext_lock_i = 1; ext_we_i = 0; ext_addr_i = 32'h0000_1000 + 32'(c * 4);
         pipe_req_i = (c >= 2); pipe_we_i = 0; pipe_addr_i = 32'h0000_0300;
         at_neg();
         chk("burst_ready", ext_ready_o, c <= 8);
         if (ext_ready_o) ready_cnt++;
         if (c == 9) begin
            chk("burst_pipe_add", DMEM_add_o, 32'h0000_0300);
            chk("burst_pipe_stall", pipe_stall_o, 0);
         end
         at_pos();
      end
      chk("burst_count", 32'(ready_cnt), 8);
      idle_inputs();
      at_neg(); at_pos();

      // Read tag steering: ext read then pipe read back to back
      ext_valid_i = 1; ext_we_i = 0; ext_addr_i = 32'h0000_0040;
      at_neg(); at_pos();
      idle_inputs();
      pipe_req_i = 1; pipe_we_i = 0; pipe_addr_i = 32'h0000_0080;
      DMEM_data_i = 32'h1111_1111;
      at_neg();
      chk("steer_rvalid1", ext_rvalid_o, 1);
      chk("steer_rdata1", ext_rdata_o, 32'h1111_1111);
      chk("steer_pipe_rd", DMEM_rd_o, 1);
      at_pos();
      idle_inputs();
      DMEM_data_i = 32'h2222_2222;
      at_neg();
      chk("steer_rvalid2", ext_rvalid_o, 0);
      chk("steer_rdata2", ext_rdata_o, 0);
      chk("steer_pipe_rdata", pipe_rdata_o, 32'h2222_2222);
      at_pos();
      idle_inputs();
      at_neg(); at_pos();

      // Reset mid-read inside a locked burst
      ext_valid_i = 1; ext_lock_i = 1; ext_we_i = 0; ext_addr_i = 32'h0000_0500;
      at_neg();
      chk("rstrd_ready", ext_ready_o, 1);
      at_pos();
      rst = 1; model_reset();
      pipe_req_i = 1; pipe_we_i = 0; pipe_addr_i = 32'h0000_0600;
      DMEM_data_i = 32'hDEAD_BEEF;
      at_neg();
      chk("rstrd_rvalid", ext_rvalid_o, 0);
      chk("rstrd_rdata", ext_rdata_o, 0);
      at_pos();
      rst = 0;
      at_neg();
      chk("rstrd_ready_after", ext_ready_o, 0);
      chk("rstrd_stall_after", pipe_stall_o, 0);
      chk("rstrd_pipe_add", DMEM_add_o, 32'h0000_0600);
      at_pos();
      idle_inputs();
      at_neg(); at_pos();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            rst = 1; model_reset();
         end else begin
            rst = 0;
         end
         pipe_req_i   = ($urandom_range(0, 1) == 1);
         pipe_we_i    = ($urandom_range(0, 2) == 0);
         pipe_addr_i  = $urandom;
         pipe_wdata_i = $urandom;
         pipe_bmask_i = 4'($urandom);
         ext_valid_i  = ($urandom_range(0, 4) < 3);
         ext_we_i     = ($urandom_range(0, 2) == 0);
         ext_lock_i   = ($urandom_range(0, 1) == 1);
         ext_addr_i   = $urandom;
         ext_wdata_i  = $urandom;
         ext_bmask_i  = 4'($urandom);
         DMEM_data_i  = $urandom;
         at_neg();
         at_pos();
      end
      rst = 0;
      check_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port, synchronous-read data memory between two requesters: the pipeline MEM stage (primary) and an external requester such as a debug or DMA port (secondary, valid/ready handshake).
- Drives the DMEM address, byte-mark, write-data and read-enable lines.
- Stalls the pipeline when the external requester wins the port.
- Tags each outstanding read so its 1-cycle-latency read data reaches the correct requester.

Parameters:
MAX_WAIT, 4, cycles an external request may be blocked before it is forced a grant (1..15)
MAX_LOCK, 8, maximum consecutive locked external beats before the port returns to the pipeline (1..15)

Ports:
clk  in  1  clock, all flops rising edge
rst  in  1  asynchronous, active-high reset
pipe_req_i  in  1  pipeline memory access this cycle
pipe_we_i  in  1  pipeline access is a write
pipe_addr_i  in  32  pipeline byte address
pipe_wdata_i  in  32  pipeline lane-aligned write data
pipe_bmask_i  in  4  pipeline byte mark
pipe_stall_o  out  1  pipeline must hold its access this cycle
pipe_rdata_o  out  32  raw DMEM word for the pipeline load, valid the cycle after grant
ext_valid_i  in  1  external request valid
ext_ready_o  out  1  external request accepted this cycle
ext_we_i  in  1  external access is a write
ext_lock_i  in  1  keep the port for the next external beat
ext_addr_i  in  32  external byte address
ext_wdata_i  in  32  external write data
ext_bmask_i  in  4  external byte mark
ext_rvalid_o  out  1  external read data valid
ext_rdata_o  out  32  external read data
DMEM_add_o  out  32  word-aligned address, {addr[31:2],2'b00}
DMEM_byte_mark_o  out  4  write byte enables; 0 on reads and idle
DMEM_data_write_o  out  32  write data
DMEM_rd_o  out  1  read strobe
DMEM_data_i  in  32  memory read data, 1-cycle latency

Behaviour:
- Clock and reset: one clock `clk`. `rst` is asynchronous, active-high, and clears every flop immediately.
- Reset values:
  - state = S_PIPE; wait_cnt = lock_cnt = 0; rd_pend = rd_owner = 0.
  - Outputs while no request is present: pipe_stall_o = 0, ext_ready_o = 0, ext_rvalid_o = 0, DMEM_byte_mark_o = 0, DMEM_rd_o = 0, DMEM_add_o = 0, DMEM_data_write_o = 0, ext_rdata_o = 0.
- FSM, two states:
  - S_PIPE: pipeline has priority. ext_grant = ext_valid_i & (~pipe_req_i | wait_cnt == MAX_WAIT). If ext_grant & ext_lock_i, go to S_EXT with lock_cnt = 1.
  - S_EXT: ext_grant = ext_valid_i. Stay while ext_valid_i & ext_lock_i & lock_cnt < MAX_LOCK; lock_cnt increments per accepted beat. Otherwise return to S_PIPE. Also return to S_PIPE with no beat if ext_valid_i = 0.
- Grant and handshake:
  - ext_ready_o = ext_grant, combinational.
  - pipe_stall_o = pipe_req_i & ext_grant.
  - pipe_grant = pipe_req_i & ~ext_grant.
- DMEM drive, combinational from the granted requester:
  - DMEM_rd_o = grant & ~we.
  - DMEM_byte_mark_o = we ? bmask : 0.
  - No grant gives all-zero drive.
- Starvation counter: wait_cnt increments (saturating at MAX_WAIT) while ext_valid_i & ~ext_grant. It clears on any ext_grant or when ext_valid_i drops.
- Read tagging:
  - On any granted read, set rd_pend = 1 and rd_owner = ext_grant; otherwise rd_pend = 0.
  - Next cycle: ext_rvalid_o = rd_pend & rd_owner, and ext_rdata_o = DMEM_data_i when ext_rvalid_o, else 0.
  - pipe_rdata_o = DMEM_data_i unconditionally; the MEM stage does its own byte/half extraction.
- Simultaneous events:
  - pipe_req_i and ext_valid_i together with wait_cnt < MAX_WAIT: pipeline wins and wait_cnt increments.
  - When wait_cnt == MAX_WAIT, ext wins for exactly one beat (or a locked burst) and pipe_stall_o = 1.
- Writes: no response is generated for either requester; the write is complete at the grant edge.
- Back-to-back: ext read followed by a pipe read on consecutive cycles routes each data word correctly, with no bubble.
- Reset mid-operation: a pending read response is dropped (ext_rvalid_o = 0) and a locked burst is abandoned.

Decomposition:
- Shared package/header (defi.vh style):
  - state encodings S_PIPE = 1'b0, S_EXT = 1'b1;
  - DMEM word-alignment mask;
  - byte-mark constants BM_NONE = 4'b0000, BM_WORD = 4'b1111.
- One natural sub-module: dmem_rd_tracker, which holds the rd_pend/rd_owner flops and the response steering.
- Arbiter FSM, counters and DMEM mux stay in the top module.

Test Plan:
- Reset idle: rst = 1, then release with no requests -> all outputs 0 and DMEM_byte_mark_o = 4'b0000.
- External read only: ext_valid_i = 1, ext_we_i = 0, ext_addr_i = 0x0000_0106, DMEM returns 0xCAFE_F00D.
  - Same cycle: ext_ready_o = 1, DMEM_add_o = 0x0000_0104, DMEM_rd_o = 1.
  - Next cycle: ext_rvalid_o = 1, ext_rdata_o = 0xCAFE_F00D.
- Pipeline/external contention:
  - pipe_req_i = 1 held continuously with ext_valid_i = 1.
  - Pipeline is granted and ext_ready_o = 0 for 4 cycles (wait_cnt 0->4).
  - 5th cycle: ext_ready_o = 1 and pipe_stall_o = 1.
  - Next cycle: pipeline granted again, wait_cnt = 0.
- Locked burst: ext_lock_i = 1, ext_valid_i = 1 for 12 beats.
  - ext_ready_o = 1 for exactly 8 consecutive beats (MAX_LOCK).
  - Then the FSM returns to S_PIPE and a pending pipe_req_i is granted.
- Read tag steering: ext read at cycle N, pipe read at N+1, DMEM data 0x11111111 then 0x22222222.
  - ext_rvalid_o = 1 only at N+1 with ext_rdata_o = 0x11111111.
  - pipe_rdata_o = 0x22222222 at N+2.
- Reset mid-read: assert rst one cycle after a granted ext read -> ext_rvalid_o stays 0 and state = S_PIPE.
